alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the 4-bit register-file/ALU datapath. Accepts one instruction at a time over a valid/ready handshake and drives the datapath's register addresses, read enable, ALU operation, write-back source select and write strobe. Returns the 4-bit result and carry over a second valid/ready handshake. Sits between an instruction source (test harness or future fetch unit) and the datapath top.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_decode.sv | 21 ++
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and instruction field layout for the ALU sequencer
package alu_seq_pkg;

  localparam int INSTR_W = 14;

  // Instruction field bit positions
  localparam int LDI_BIT = 13;
  localparam int OPER_HI = 12;
  localparam int OPER_LO = 10;
  localparam int WR_HI   = 9;
  localparam int WR_LO   = 8;
  localparam int RS1_HI  = 7;
  localparam int RS1_LO  = 6;
  localparam int RS2_HI  = 5;
  localparam int RS2_LO  = 4;
  localparam int IMM_HI  = 3;
  localparam int IMM_LO  = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational field split of the latched instruction
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               ldi,
  output logic [2:0]         oper,
  output logic [1:0]         wr,
  output logic [1:0]         rs1,
  output logic [1:0]         rs2,
  output logic [3:0]         imm
);

  assign ldi  = instr[LDI_BIT];
  assign oper = instr[OPER_HI:OPER_LO];
  assign wr   = instr[WR_HI:WR_LO];
  assign rs1  = instr[RS1_HI:RS1_LO];
  assign rs2  = instr[RS2_HI:RS2_LO];
  assign imm  = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle sequencer for the 4-bit regfile/ALU datapath (optional flags: ALU_SEQ_FLAGS_EN)
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int RET_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [INSTR_W-1:0]   instr,
  output logic                 instr_ready,
  output logic [1:0]           dp_rd1,
  output logic [1:0]           dp_rd2,
  output logic                 dp_read_en,
  output logic [2:0]           dp_oper,
  output logic [1:0]           dp_wr,
  output logic                 dp_wr_en,
  output logic                 dp_src_imm,
  output logic [3:0]           dp_data_in,
  input  logic [3:0]           dp_res,
  input  logic                 dp_carry,
  output logic                 rsp_valid,
  output logic [3:0]           rsp_res,
  output logic                 rsp_carry,
  input  logic                 rsp_ready,
  output logic [RET_CNT_W-1:0] ret_cnt
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                 rsp_zero,
  output logic                 carry_seen
`endif
);

  state_t               state;
  state_t               state_nxt;
  logic [INSTR_W-1:0]   instr_q;
  logic [3:0]           res_q;
  logic                 carry_q;
  logic                 f_ldi;
  logic [2:0]           f_oper;
  logic [1:0]           f_wr;
  logic [1:0]           f_rs1;
  logic [1:0]           f_rs2;
  logic [3:0]           f_imm;
  logic                 accept;

  alu_seq_decode u_decode (
    .instr (instr_q),
    .ldi   (f_ldi),
    .oper  (f_oper),
    .wr    (f_wr),
    .rs1   (f_rs1),
    .rs2   (f_rs2),
    .imm   (f_imm)
  );

  assign accept = instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake/enable decode
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    dp_read_en  = 1'b0;
    dp_wr_en    = 1'b0;
    dp_src_imm  = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = instr[LDI_BIT] ? WB : READ;
      end
      READ: begin
        dp_read_en = 1'b1;
        state_nxt  = EXEC;
      end
      EXEC: begin
        dp_read_en = 1'b1;
        state_nxt  = WB;
      end
      WB: begin
        // Suppress the strobe while reset is asserted so an aborted op never writes
        dp_wr_en   = !reset;
        dp_src_imm = f_ldi;
        state_nxt  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath-facing fields always come from the latched instruction
  assign dp_rd1     = f_rs1;
  assign dp_rd2     = f_rs2;
  assign dp_oper    = f_oper;
  assign dp_wr      = f_wr;
  assign dp_data_in = f_imm;
  assign rsp_res    = res_q;
  assign rsp_carry  = carry_q;

  // Instruction latch, result register and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ret_cnt <= '0;
    end else begin
      if (accept) instr_q <= instr;
      if (state == EXEC) begin
        res_q   <= dp_res;
        carry_q <= dp_carry;
      end else if (state == WB && f_ldi) begin
        res_q   <= f_imm;
        carry_q <= 1'b0;
      end
      if (state == RESP && rsp_ready) ret_cnt <= ret_cnt + RET_CNT_W'(1);
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Zero flag tracks the result register; carry_seen is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_zero   <= 1'b1;
      carry_seen <= 1'b0;
    end else begin
      if (state == EXEC) begin
        rsp_zero <= (dp_res == 4'd0);
        if (dp_carry) carry_seen <= 1'b1;
      end else if (state == WB && f_ldi) begin
        rsp_zero <= (f_imm == 4'd0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

  localparam int RET_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 instr_valid;
  logic [13:0]          instr;
  logic                 instr_ready;
  logic [1:0]           dp_rd1, dp_rd2, dp_wr;
  logic                 dp_read_en, dp_wr_en, dp_src_imm;
  logic [2:0]           dp_oper;
  logic [3:0]           dp_data_in, dp_res;
  logic                 dp_carry;
  logic                 rsp_valid, rsp_carry, rsp_ready;
  logic [3:0]           rsp_res;
  logic [RET_CNT_W-1:0] ret_cnt;
`ifdef ALU_SEQ_FLAGS_EN
  logic                 rsp_zero, carry_seen;
`endif

  alu_seq_ctrl #(.RET_CNT_W(RET_CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .dp_rd1      (dp_rd1),
    .dp_rd2      (dp_rd2),
    .dp_read_en  (dp_read_en),
    .dp_oper     (dp_oper),
    .dp_wr       (dp_wr),
    .dp_wr_en    (dp_wr_en),
    .dp_src_imm  (dp_src_imm),
    .dp_data_in  (dp_data_in),
    .dp_res      (dp_res),
    .dp_carry    (dp_carry),
    .rsp_valid   (rsp_valid),
    .rsp_res     (rsp_res),
    .rsp_carry   (rsp_carry),
    .rsp_ready   (rsp_ready),
    .ret_cnt     (ret_cnt)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .rsp_zero    (rsp_zero),
    .carry_seen  (carry_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ldi;
    logic [2:0] oper;
    logic [1:0] wr;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] imm;
    logic [3:0] mres;
    logic       mcarry;
    logic [3:0] exp_res;
    logic       exp_carry;
    int         stall;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       carry;
  } rsp_t;

  vec_t                 vecs[6];
  rsp_t                 sb[$];
  int                   n_chk = 0;
  int                   n_fail = 0;
  logic [RET_CNT_W-1:0] exp_ret = '0;
  logic                 exp_cs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic [2:0] o, input logic [1:0] w,
                              input logic [1:0] a, input logic [1:0] b, input logic [3:0] im,
                              input logic [3:0] mr, input logic mc, input logic [3:0] er,
                              input logic ec, input int st);
    vec_t v;
    v.ldi = l; v.oper = o; v.wr = w; v.rs1 = a; v.rs2 = b; v.imm = im;
    v.mres = mr; v.mcarry = mc; v.exp_res = er; v.exp_carry = ec; v.stall = st;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_instr_ready"}, instr_ready, 1);
    chk({tag, "_rsp_valid"},   rsp_valid, 0);
    chk({tag, "_read_en"},     dp_read_en, 0);
    chk({tag, "_wr_en"},       dp_wr_en, 0);
    chk({tag, "_src_imm"},     dp_src_imm, 0);
    chk({tag, "_addr_oper"},   {dp_rd1, dp_rd2, dp_wr, dp_oper}, 0);
    chk({tag, "_data_in"},     dp_data_in, 0);
    chk({tag, "_rsp_data"},    {rsp_res, rsp_carry}, 0);
    chk({tag, "_ret_cnt"},     ret_cnt, 0);
  endtask

  // Entered and left at a negedge with the DUT idle
  task automatic do_instr(input vec_t v);
    logic [13:0] ins;
    int          lat, rd_cnt, wr_cnt;
    logic [3:0]  held_res;
    logic        held_c;
    rsp_t        e;
    ins = {v.ldi, v.oper, v.wr, v.rs1, v.rs2, v.imm};
    chk("instr_ready_idle", instr_ready, 1);
    instr = ins; instr_valid = 1'b1; dp_res = v.mres; dp_carry = v.mcarry;
    sb.push_back('{v.exp_res, v.exp_carry});
    if (!v.ldi && v.mcarry) exp_cs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = ~ins;
    lat = 0; rd_cnt = 0; wr_cnt = 0;
    while (!rsp_valid && lat < 20) begin
      lat++;
      if (dp_read_en) begin
        rd_cnt++;
        chk("rd_addrs_oper", {dp_rd1, dp_rd2, dp_oper}, {v.rs1, v.rs2, v.oper});
      end
      if (dp_wr_en) begin
        wr_cnt++;
        chk("wb_addr", dp_wr, v.wr);
        chk("wb_src_imm", dp_src_imm, v.ldi);
        if (v.ldi) chk("wb_data_in", dp_data_in, v.imm);
        dp_res = ~v.mres; dp_carry = ~v.mcarry;
      end else begin
        chk("src_imm_inactive", dp_src_imm, 0);
      end
      @(negedge clk);
    end
    chk("latency", lat, v.ldi ? 1 : 3);
    chk("read_en_cycles", rd_cnt, v.ldi ? 0 : 2);
    chk("wr_en_pulses", wr_cnt, 1);
    if (!rsp_valid) begin
      void'(sb.pop_front());
      return;
    end
    held_res = rsp_res; held_c = rsp_carry;
    repeat (v.stall) begin
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", {rsp_res, rsp_carry}, {held_res, held_c});
      chk("stall_instr_ready", instr_ready, 0);
      chk("stall_ret_cnt", ret_cnt, exp_ret);
      chk("stall_wr_en", dp_wr_en, 0);
      instr = ins ^ 14'h2000; instr_valid = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    rsp_ready = 1'b1;
    e = sb.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_res", rsp_res, e.res);
    chk("rsp_carry", rsp_carry, e.carry);
`ifdef ALU_SEQ_FLAGS_EN
    chk("rsp_zero", rsp_zero, (e.res == 4'd0));
    chk("carry_seen", carry_seen, exp_cs);
`endif
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ret = exp_ret + 1'b1;
    chk("ret_cnt", ret_cnt, exp_ret);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_instr_ready", instr_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w;
    vecs[0] = mk(1, 3'd0, 2'd2, 2'd0, 2'd0, 4'hA, 4'h0, 1'b0, 4'hA, 1'b0, 0);
    vecs[1] = mk(0, 3'd0, 2'd3, 2'd1, 2'd2, 4'h0, 4'h3, 1'b1, 4'h3, 1'b1, 0);
    vecs[2] = mk(0, 3'd5, 2'd1, 2'd3, 2'd0, 4'h7, 4'hF, 1'b0, 4'hF, 1'b0, 5);
    vecs[3] = mk(1, 3'd7, 2'd0, 2'd2, 2'd1, 4'h0, 4'h9, 1'b1, 4'h0, 1'b0, 2);
    vecs[4] = mk(0, 3'd2, 2'd2, 2'd0, 2'd3, 4'hC, 4'h0, 1'b0, 4'h0, 1'b0, 1);
    vecs[5] = mk(1, 3'd1, 2'd1, 2'd1, 2'd1, 4'h5, 4'h6, 1'b1, 4'h5, 1'b0, 0);

    reset = 1'b1; instr_valid = 1'b0; instr = '0; dp_res = '0; dp_carry = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst_rel");

    for (int i = 0; i < 6; i++) do_instr(vecs[i]);

    // Reset while in EXEC: abort without a write strobe
    instr = {1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 4'h0}; instr_valid = 1'b1; dp_res = 4'h6; dp_carry = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_read_en", dp_read_en, 1);
    reset = 1'b1;
    chk("exec_reset_wr_en", dp_wr_en, 0);
    @(posedge clk);
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b0;
    exp_ret = '0; exp_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_wr_en", dp_wr_en, 0);
      chk("abort_idle", instr_ready, 1);
      @(negedge clk);
    end
`ifdef ALU_SEQ_FLAGS_EN
    chk("carry_seen_cleared", carry_seen, 0);
`endif

    // Counter wrap: 2^RET_CNT_W + 1 retirements
    w = mk(1, 3'd0, 2'd1, 2'd0, 2'd0, 4'h3, 4'h0, 1'b0, 4'h3, 1'b0, 0);
    for (int i = 0; i < (1 << RET_CNT_W) + 1; i++) begin
      w.imm = 4'(i); w.exp_res = 4'(i);
      do_instr(w);
    end
    chk("ret_cnt_wrap", ret_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
